inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  decode stage not accepting; hold current output and PC.
REQ-005 br_valid  input  1  decode resolved taken branch/jump (Beq taken, Jump, JumpV).
REQ-006 br_target  input  32  target of that branch/jump.
REQ-007 flush  input  1  exception/eret redirect; overrides everything.
REQ-008 flush_pc  input  32  redirect address for flush.
REQ-009 inst_sram_en  output  1  fetch request this cycle.
REQ-010 inst_sram_wen  output  4  write enables; constant 4'b0000.
REQ-011 inst_sram_addr  output  32  fetch address, equal to pc.
REQ-012 inst_sram_wdata  output  32  constant 32'h0.
REQ-013 inst_sram_rdata  input  32  instruction returned one cycle after request.
REQ-014 id_valid  output  1  id_pc/id_inst/id_adel valid for decode.
REQ-015 id_pc  output  32  address of delivered instruction.
REQ-016 id_inst  output  32  delivered instruction word (opcode [31:26], rt [20:16], funct [5:0]).
REQ-017 id_adel  output  1  delivered slot is a misaligned-fetch (AdEL) fault.

Function
REQ-018 States: RUN (output from live rdata) and HOLD (output from hold buffer); reset enters RUN.
REQ-019 Request: in any cycle with resetn=1, stall=0, flush=0 and pc[1:0]=2'b00, inst_sram_en=1 and inst_sram_addr=pc.
REQ-020 Latency: instruction requested in cycle N appears on id_* with id_valid=1 in cycle N+1, id_inst=inst_sram_rdata combinationally in RUN.
REQ-021 PC update when stall=0: flush ? flush_pc : br_valid ? br_target : pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
REQ-022 Delay slot: the fetch in flight when br_valid is seen is delivered unchanged; only the following fetch uses br_target.
REQ-023 br_valid is sampled only when stall=0; the source holds it asserted through stall.
REQ-024 Stall: inst_sram_en=0, pc unchanged, id_valid/id_pc/id_inst/id_adel unchanged for every stalled cycle.
REQ-025 RUN->HOLD on first stall cycle with id_valid=1: hold buffer captures inst_sram_rdata; HOLD->RUN when stall deasserts, the next request issuing that same cycle.
REQ-026 Misaligned pc (pc[1:0]!=0): inst_sram_en=0; next cycle id_valid=1, id_pc=pc, id_inst=0, id_adel=1; pc advances per REQ-021.
REQ-027 Flush (any state, stall ignored): pc<=flush_pc, next-cycle id_valid=0, hold buffer discarded, state->RUN, no request in flush cycle.
REQ-028 Simultaneous flush and br_valid: flush wins; br_target discarded.
REQ-029 id_valid=0 in any cycle whose preceding cycle issued no request and produced no AdEL slot, except under REQ-024.

Reset
REQ-030 During reset: pc=RESET_PC, state RUN, id_valid=0, id_pc=0, id_inst=0, id_adel=0, inst_sram_en=0, hold buffer cleared.
REQ-031 First request (addr RESET_PC) issues in the first cycle after resetn rises; reset mid-stall or mid-flush abandons all state.

Structure
REQ-032 RESET_PC value and exception vector 32'hBFC0_0380 live in the shared CPU package.
REQ-033 One sub-module, fetch_hold_buf: hold register plus RUN/HOLD state and output mux.

Verification
REQ-034 Reset release, rdata=PC-indexed pattern, no stall -> addr BFC00000, BFC00004, BFC00008 on consecutive cycles, id_pc lags one cycle.
REQ-035 br_valid=1, br_target=BFC00100 while fetching BFC00008 -> BFC00008 delivered (delay slot), next addr BFC00100.
REQ-036 stall 3 cycles while id_inst=24020001, rdata changes to FFFFFFFF -> id_inst stays 24020001, en=0 throughout, resumes at next pc.
REQ-037 flush=1, flush_pc=BFC00380 during stall with br_valid=1 -> next cycle id_valid=0, following addr BFC00380.
REQ-038 br_target=BFC00102 -> no request for it; next cycle id_valid=1, id_adel=1, id_inst=0, id_pc=BFC00102.
REQ-039 resetn deasserted mid-HOLD -> all outputs at reset values immediately, first fetch BFC00000 after release.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inst_fetch_pkg : shared CPU constants and fetch-slot type  | Rev 1.0
// ----------------------------------------------------------------------------
package inst_fetch_pkg;

  localparam logic [31:0] CPU_RESET_PC   = 32'hBFC0_0000;
  localparam logic [31:0] CPU_EXC_VECTOR = 32'hBFC0_0380;

  // Slot presented to decode; req marks that the word comes from the SRAM.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        adel;
    logic        req;
  } id_slot_t;

  function automatic logic pc_aligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_hold_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_hold_buf : RUN/HOLD state, hold register and id_inst output mux  | Rev 1.0
// ----------------------------------------------------------------------------
module fetch_hold_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid_i,
  input  logic [31:0] live_inst_i,
  output logic [31:0] id_inst_o
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (flush) begin
      state_d = ST_RUN;
      hold_d  = 32'h0;
    end else if (state_q == ST_RUN) begin
      // rdata is only guaranteed for one cycle, so latch it on the first stall.
      if (stall && id_valid_i) begin
        state_d = ST_HOLD;
        hold_d  = live_inst_i;
      end
    end else if (!stall) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign id_inst_o = (state_q == ST_HOLD) ? hold_q : live_inst_i;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inst_fetch : PC sequencing, SRAM fetch request and decode-slot delivery  | Rev 1.0
// ----------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  logic [31:0] pc_q, pc_d;
  id_slot_t    slot_q, slot_d;
  logic        aligned;
  logic [31:0] live_inst;

  assign aligned = pc_aligned(pc_q);

  always_comb begin
    pc_d   = pc_q;
    slot_d = slot_q;
    if (flush) begin
      pc_d         = flush_pc;
      slot_d.valid = 1'b0;
      slot_d.adel  = 1'b0;
      slot_d.req   = 1'b0;
    end else if (!stall) begin
      // The fetch issued alongside a taken branch is its delay slot.
      pc_d         = br_valid ? br_target : pc_q + 32'd4;
      slot_d.valid = 1'b1;
      slot_d.pc    = pc_q;
      slot_d.adel  = ~aligned;
      slot_d.req   = aligned;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q   <= RESET_PC;
      slot_q <= '0;
    end else begin
      pc_q   <= pc_d;
      slot_q <= slot_d;
    end
  end

  assign live_inst = slot_q.req ? inst_sram_rdata : 32'h0;

  fetch_hold_buf u_hold_buf (
    .clk         (clk),
    .resetn      (resetn),
    .stall       (stall),
    .flush       (flush),
    .id_valid_i  (slot_q.valid),
    .live_inst_i (live_inst),
    .id_inst_o   (id_inst)
  );

  assign inst_sram_en    = resetn & ~stall & ~flush & aligned;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wdata = 32'h0;
  assign id_valid        = slot_q.valid;
  assign id_pc           = slot_q.pc;
  assign id_adel         = slot_q.adel;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_inst_fetch : self-checking bench for inst_fetch  | Rev 1.0
// ----------------------------------------------------------------------------
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  int checks = 0;
  int errors = 0;
  bit rnd_garbage = 1'b0;

  // Reference model: current pc and the slot decode should be seeing.
  logic [31:0] m_pc = CPU_RESET_PC;
  logic        m_valid = 1'b0;
  logic [31:0] m_slot_pc = 32'h0;
  logic        m_adel = 1'b0;

  inst_fetch #(.RESET_PC(CPU_RESET_PC)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .br_valid        (br_valid),
    .br_target       (br_target),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .id_adel         (id_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hBFC0_0100) return 32'h2402_0001;
    return a ^ 32'h3C1D_A5F0;
  endfunction

  // Synchronous-read instruction SRAM; unrequested cycles return junk.
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? mem(inst_sram_addr)
                                    : (rnd_garbage ? $urandom : 32'hFFFF_FFFF);

  task automatic model_reset();
    m_pc = CPU_RESET_PC; m_valid = 1'b0; m_slot_pc = 32'h0; m_adel = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    if (resetn) begin
      if (flush) begin
        m_pc = flush_pc; m_valid = 1'b0; m_adel = 1'b0;
      end else if (!stall) begin
        m_valid = 1'b1; m_slot_pc = m_pc; m_adel = (m_pc % 4) != 0;
        m_pc = br_valid ? br_target : m_pc + 32'd4;
      end
    end
    #2;
  endtask

  task automatic test_reset();
    resetn = 1'b0; model_reset();
    step(); step(); #1;
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", inst_sram_en); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", id_pc); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", id_inst); end
    checks++; if (id_adel !== 1'b0) begin errors++; $display("FAIL reset_adel: got %b expected 0", id_adel); end
    checks++; if (inst_sram_wen !== 4'h0 || inst_sram_wdata !== 32'h0) begin errors++; $display("FAIL reset_wr: got %h/%h expected 0/0", inst_sram_wen, inst_sram_wdata); end
    checks++; if (inst_sram_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_addr: got %h expected bfc00000", inst_sram_addr); end
  endtask

  task automatic test_sequential();
    resetn = 1'b1; #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL seq_first: got en=%b addr=%h expected 1/bfc00000", inst_sram_en, inst_sram_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL seq_valid0: got %b expected 0", id_valid); end
    step(); #1;
    checks++; if (inst_sram_addr !== 32'hBFC0_0004 || id_pc !== 32'hBFC0_0000 || id_valid !== 1'b1) begin errors++; $display("FAIL seq_second: got addr=%h id_pc=%h v=%b expected bfc00004/bfc00000/1", inst_sram_addr, id_pc, id_valid); end
    checks++; if (id_inst !== mem(32'hBFC0_0000)) begin errors++; $display("FAIL seq_inst: got %h expected %h", id_inst, mem(32'hBFC0_0000)); end
    step(); #1;
    checks++; if (inst_sram_addr !== 32'hBFC0_0008 || id_pc !== 32'hBFC0_0004) begin errors++; $display("FAIL seq_third: got addr=%h id_pc=%h expected bfc00008/bfc00004", inst_sram_addr, id_pc); end
  endtask

  task automatic test_delay_slot();
    br_valid = 1'b1; br_target = 32'hBFC0_0100; #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0008) begin errors++; $display("FAIL ds_fetch: got en=%b addr=%h expected 1/bfc00008", inst_sram_en, inst_sram_addr); end
    step(); br_valid = 1'b0; #1;
    checks++; if (id_pc !== 32'hBFC0_0008 || id_inst !== mem(32'hBFC0_0008)) begin errors++; $display("FAIL ds_slot: got pc=%h inst=%h expected bfc00008/%h", id_pc, id_inst, mem(32'hBFC0_0008)); end
    checks++; if (inst_sram_addr !== 32'hBFC0_0100 || inst_sram_en !== 1'b1) begin errors++; $display("FAIL ds_target: got addr=%h en=%b expected bfc00100/1", inst_sram_addr, inst_sram_en); end
  endtask

  task automatic test_stall();
    step(); #1;
    checks++; if (id_inst !== 32'h2402_0001 || id_pc !== 32'hBFC0_0100) begin errors++; $display("FAIL st_pre: got inst=%h pc=%h expected 24020001/bfc00100", id_inst, id_pc); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (inst_sram_en !== 1'b0 || id_inst !== 32'h2402_0001 || id_valid !== 1'b1 || id_pc !== 32'hBFC0_0100 || inst_sram_addr !== 32'hBFC0_0104) begin
        errors++; $display("FAIL st_hold%0d: got en=%b inst=%h v=%b pc=%h addr=%h expected 0/24020001/1/bfc00100/bfc00104", i, inst_sram_en, id_inst, id_valid, id_pc, inst_sram_addr);
      end
      step();
    end
    stall = 1'b0; #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0104 || id_inst !== 32'h2402_0001) begin errors++; $display("FAIL st_release: got en=%b addr=%h inst=%h expected 1/bfc00104/24020001", inst_sram_en, inst_sram_addr, id_inst); end
    step(); #1;
    checks++; if (id_pc !== 32'hBFC0_0104 || id_inst !== mem(32'hBFC0_0104)) begin errors++; $display("FAIL st_resume: got pc=%h inst=%h expected bfc00104/%h", id_pc, id_inst, mem(32'hBFC0_0104)); end
  endtask

  task automatic test_flush();
    stall = 1'b1; br_valid = 1'b1; br_target = 32'hBFC0_0200; #1;
    step(); flush = 1'b1; flush_pc = CPU_EXC_VECTOR; #1;
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL fl_noreq: got %b expected 0", inst_sram_en); end
    step(); flush = 1'b0; stall = 1'b0; br_valid = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b expected 0", id_valid); end
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0380) begin errors++; $display("FAIL fl_addr: got en=%b addr=%h expected 1/bfc00380", inst_sram_en, inst_sram_addr); end
    step(); #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL fl_slot: got v=%b pc=%h expected 1/bfc00380", id_valid, id_pc); end
  endtask

  task automatic test_misaligned();
    br_valid = 1'b1; br_target = 32'hBFC0_0102; #1;
    step(); br_valid = 1'b0; #1;
    checks++; if (inst_sram_en !== 1'b0 || inst_sram_addr !== 32'hBFC0_0102) begin errors++; $display("FAIL ma_noreq: got en=%b addr=%h expected 0/bfc00102", inst_sram_en, inst_sram_addr); end
    step(); #1;
    checks++; if (id_valid !== 1'b1 || id_adel !== 1'b1 || id_inst !== 32'h0 || id_pc !== 32'hBFC0_0102) begin errors++; $display("FAIL ma_slot: got v=%b adel=%b inst=%h pc=%h expected 1/1/0/bfc00102", id_valid, id_adel, id_inst, id_pc); end
    br_valid = 1'b1; br_target = 32'hBFC0_0200;
    step(); br_valid = 1'b0; #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0200) begin errors++; $display("FAIL ma_recover: got en=%b addr=%h expected 1/bfc00200", inst_sram_en, inst_sram_addr); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    step(); flush = 1'b0; #1;
    step(); #1;
    checks++; if (inst_sram_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap: got addr=%h id_pc=%h expected 0/fffffffc", inst_sram_addr, id_pc); end
  endtask

  task automatic test_reset_mid_hold();
    step(); stall = 1'b1;
    step(); step();
    resetn = 1'b0; model_reset(); #1;
    checks++; if (inst_sram_en !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0 || id_adel !== 1'b0) begin
      errors++; $display("FAIL rh_reset: got en=%b v=%b pc=%h inst=%h adel=%b expected all 0", inst_sram_en, id_valid, id_pc, id_inst, id_adel);
    end
    step(); stall = 1'b0; resetn = 1'b1; #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0000 || id_valid !== 1'b0) begin errors++; $display("FAIL rh_first: got en=%b addr=%h v=%b expected 1/bfc00000/0", inst_sram_en, inst_sram_addr, id_valid); end
    step(); #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC0_0000 || id_inst !== mem(32'hBFC0_0000)) begin errors++; $display("FAIL rh_slot: got v=%b pc=%h inst=%h expected 1/bfc00000/%h", id_valid, id_pc, id_inst, mem(32'hBFC0_0000)); end
  endtask

  task automatic test_random();
    logic [31:0] exp_inst;
    rnd_garbage = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stall     = ($urandom % 4) == 0;
      flush     = ($urandom % 16) == 0;
      br_valid  = ($urandom % 4) == 0;
      br_target = {20'hBFC01, $urandom_range(0, 4095) & 32'hFFC} | (($urandom % 8 == 0) ? 32'd2 : 32'd0);
      flush_pc  = ($urandom % 4 == 0) ? 32'hFFFF_FFFC : CPU_EXC_VECTOR;
      #1;
      checks++; if (inst_sram_en !== (!stall && !flush && (m_pc % 4) == 0)) begin errors++; $display("FAIL rnd_en[%0d]: got %b", i, inst_sram_en); end
      checks++; if (inst_sram_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, inst_sram_addr, m_pc); end
      checks++; if (id_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, id_valid, m_valid); end
      if (m_valid) begin
        exp_inst = m_adel ? 32'h0 : mem(m_slot_pc);
        checks++; if (id_pc !== m_slot_pc || id_adel !== m_adel) begin errors++; $display("FAIL rnd_slot[%0d]: got pc=%h adel=%b expected %h/%b", i, id_pc, id_adel, m_slot_pc, m_adel); end
        checks++; if (id_inst !== exp_inst) begin errors++; $display("FAIL rnd_inst[%0d]: got %h expected %h", i, id_inst, exp_inst); end
      end
      step();
    end
    stall = 1'b0; flush = 1'b0; br_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_delay_slot();
    test_stall();
    test_flush();
    test_misaligned();
    test_wrap();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
